// File: rtl/noc_arb_pkg.sv
// rtl/noc_arb_pkg.sv - shared types and helpers for NoC round-robin arbiters
package noc_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Index width for n entries, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/onehot_mux.sv
// rtl/onehot_mux.sv - AND-OR one-hot multiplexer, zero output when select is empty
module onehot_mux #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic [N-1:0]        sel,
    input  logic [N-1:0][W-1:0] data,
    output logic [W-1:0]        out
);

    always_comb begin
        out = '0;
        for (int i = 0; i < N; i++) begin
            out |= data[i] & {W{sel[i]}};
        end
    end

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick, searching upward from prio_ptr with wrap
module rr_pick
    import noc_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int IdxW = idx_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] prio_ptr,
    output logic [N-1:0]    winner_oh,
    output logic [IdxW-1:0] winner_idx
);

    logic [N-1:0] mask;
    logic [N-1:0] masked;
    logic [N-1:0] pick_src;

    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (IdxW'(i) >= prio_ptr);
        end
    end

    // Requests at or above the pointer win; otherwise fall back to the wrapped search.
    assign masked    = req & mask;
    assign pick_src  = (|masked) ? masked : req;
    assign winner_oh = pick_src & (~pick_src + N'(1));

    always_comb begin
        winner_idx = '0;
        for (int i = 0; i < N; i++) begin
            winner_idx |= winner_oh[i] ? IdxW'(i) : '0;
        end
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// rtl/rr_lock_arbiter.sv - round-robin arbiter with packet (wormhole) grant locking
module rr_lock_arbiter
    import noc_arb_pkg::*;
#(
    parameter int InputWidth = 4,
    parameter int DataWidth  = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [InputWidth-1:0]                 req_valid_i,
    input  logic [InputWidth-1:0]                 req_last_i,
    input  logic [InputWidth-1:0][DataWidth-1:0]  req_data_i,
    output logic [InputWidth-1:0]                 req_ready_o,
    output logic                                  out_valid_o,
    output logic                                  out_last_o,
    output logic [DataWidth-1:0]                  out_data_o,
    input  logic                                  out_ready_i,
    output logic [InputWidth-1:0]                 grant_oh_o,
    output logic                                  locked_o
);

    localparam int IdxW = idx_width(InputWidth);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(InputWidth - 1);

    arb_state_e            state_q, state_d;
    logic [IdxW-1:0]       prio_ptr_q, prio_ptr_d;
    logic [IdxW-1:0]       lock_idx_q, lock_idx_d;
    logic [IdxW-1:0]       pick_idx, grant_idx;
    logic [InputWidth-1:0] pick_oh, grant_oh;
    logic                  fire;

    // Explicit wrap so non-power-of-two widths never index past the last requester.
    function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] idx);
        return (idx == LastIdx) ? '0 : idx + 1'b1;
    endfunction

    rr_pick #(
        .N    (InputWidth),
        .IdxW (IdxW)
    ) u_pick (
        .req        (req_valid_i),
        .prio_ptr   (prio_ptr_q),
        .winner_oh  (pick_oh),
        .winner_idx (pick_idx)
    );

    onehot_mux #(
        .N (InputWidth),
        .W (DataWidth)
    ) u_data_mux (
        .sel  (grant_oh),
        .data (req_data_i),
        .out  (out_data_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ARB_IDLE;
            prio_ptr_q <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            prio_ptr_q <= prio_ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        prio_ptr_d = prio_ptr_q;
        lock_idx_d = lock_idx_q;
        if (fire) begin
            if (out_last_o) begin
                state_d    = ARB_IDLE;
                prio_ptr_d = wrap_inc(grant_idx);
            end else if (state_q == ARB_IDLE) begin
                state_d    = ARB_LOCKED;
                lock_idx_d = grant_idx;
            end
        end
    end

    // Grant is forced empty while reset is held so outputs drop without a clock edge.
    always_comb begin
        grant_oh  = '0;
        grant_idx = pick_idx;
        if (!rst_i) begin
            if (state_q == ARB_LOCKED) begin
                grant_oh  = InputWidth'(1) << lock_idx_q;
                grant_idx = lock_idx_q;
            end else begin
                grant_oh = pick_oh;
            end
        end
    end

    assign out_valid_o = |(grant_oh & req_valid_i);
    assign out_last_o  = |(grant_oh & req_last_i);
    assign req_ready_o = grant_oh & {InputWidth{out_ready_i}};
    assign grant_oh_o  = grant_oh;
    assign locked_o    = (state_q == ARB_LOCKED);
    assign fire        = out_valid_o & out_ready_i;

    a_grant_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(grant_oh_o));

    a_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(req_ready_o));

    a_lock_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == ARB_LOCKED && !(fire && out_last_o)) |=> $stable(grant_oh_o));

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb/tb_rr_lock_arbiter.sv - scoreboard bench for rr_lock_arbiter at 4 and 3 requesters
module tb_rr_lock_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]       valid = '0;
    logic [3:0]       last  = '0;
    logic             ready = 1'b0;
    logic [3:0][31:0] data  = '0;

    logic [3:0]  g4, r4;
    logic        v4, l4, lk4;
    logic [31:0] d4;
    logic [2:0]  g3, r3;
    logic        v3, l3, lk3;
    logic [31:0] d3;

    rr_lock_arbiter #(.InputWidth(4), .DataWidth(32)) dut4 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(valid), .req_last_i(last), .req_data_i(data),
        .req_ready_o(r4), .out_valid_o(v4), .out_last_o(l4), .out_data_o(d4),
        .out_ready_i(ready), .grant_oh_o(g4), .locked_o(lk4)
    );

    rr_lock_arbiter #(.InputWidth(3), .DataWidth(32)) dut3 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(valid[2:0]), .req_last_i(last[2:0]), .req_data_i(data[2:0]),
        .req_ready_o(r3), .out_valid_o(v3), .out_last_o(l3), .out_data_o(d3),
        .out_ready_i(ready), .grant_oh_o(g3), .locked_o(lk3)
    );

    typedef struct {
        logic [3:0]  grant;
        logic [3:0]  ready;
        logic        valid;
        logic        last;
        logic [31:0] data;
        logic        locked;
    } exp_t;

    exp_t q4[$];
    exp_t q3[$];
    int n_cmp = 0;
    int n_err = 0;

    // Reference: owner < 0 means no packet in progress; ptr is the requester searched first.
    int m_n[2]     = '{4, 3};
    int m_ptr[2]   = '{0, 0};
    int m_owner[2] = '{-1, -1};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d]   = 0;
            m_owner[d] = -1;
        end
    endtask

    task automatic model_step(input int d, output exp_t e);
        int n, g;
        n = m_n[d];
        g = -1;
        if (m_owner[d] >= 0) begin
            g = m_owner[d];
        end else begin
            for (int k = 0; k < n; k++) begin
                int idx;
                idx = (m_ptr[d] + k) % n;
                if (g < 0 && valid[idx]) g = idx;
            end
        end
        e.grant  = (g >= 0) ? 4'(1 << g) : 4'd0;
        e.ready  = ready ? e.grant : 4'd0;
        e.valid  = (g >= 0) ? valid[g] : 1'b0;
        e.last   = (g >= 0) ? last[g] : 1'b0;
        e.data   = (g >= 0) ? data[g] : 32'd0;
        e.locked = (m_owner[d] >= 0);
        if (e.valid && ready) begin
            if (last[g]) begin
                m_owner[d] = -1;
                m_ptr[d]   = (g + 1) % n;
            end else begin
                m_owner[d] = g;
            end
        end
    endtask

    task automatic cycle(input logic [3:0] v, input logic [3:0] l, input logic rdy);
        exp_t e;
        @(posedge clk);
        #1;
        valid = v;
        last  = l;
        ready = rdy;
        for (int i = 0; i < 4; i++) data[i] = $urandom;
        model_step(0, e);
        q4.push_back(e);
        model_step(1, e);
        q3.push_back(e);
    endtask

    task automatic cmp_rec(input string tag, input exp_t e, input logic [3:0] g,
                           input logic [3:0] r, input logic v, input logic l,
                           input logic [31:0] dt, input logic lk);
        chk({tag, " grant"},  64'(g),  64'(e.grant));
        chk({tag, " ready"},  64'(r),  64'(e.ready));
        chk({tag, " valid"},  64'(v),  64'(e.valid));
        chk({tag, " last"},   64'(l),  64'(e.last));
        chk({tag, " data"},   64'(dt), 64'(e.data));
        chk({tag, " locked"}, 64'(lk), 64'(e.locked));
    endtask

    always @(negedge clk) begin
        if (q4.size() > 0) cmp_rec("n4", q4.pop_front(), g4, r4, v4, l4, d4, lk4);
        if (q3.size() > 0) cmp_rec("n3", q3.pop_front(), {1'b0, g3}, {1'b0, r3}, v3, l3, d3, lk3);
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, " n4 grant"},  64'(g4),  64'd0);
        chk({tag, " n4 locked"}, 64'(lk4), 64'd0);
        chk({tag, " n4 valid"},  64'(v4),  64'd0);
        chk({tag, " n4 ready"},  64'(r4),  64'd0);
        chk({tag, " n4 data"},   64'(d4),  64'd0);
        chk({tag, " n4 last"},   64'(l4),  64'd0);
        chk({tag, " n3 grant"},  64'(g3),  64'd0);
        chk({tag, " n3 locked"}, 64'(lk3), 64'd0);
    endtask

    initial begin
        // Requests held active during reset: outputs must still read zero.
        valid = 4'hF;
        last  = 4'hF;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) data[i] = $urandom;
        #12;
        check_reset_outputs("reset");
        valid = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Single-beat round robin: 0,1,2,3,0
        repeat (5) cycle(4'hF, 4'hF, 1'b1);

        // Three-beat packet from requester 1 with requester 2 waiting
        cycle(4'b0110, 4'b0100, 1'b1);
        cycle(4'b0110, 4'b0100, 1'b1);
        cycle(4'b0110, 4'b0110, 1'b1);
        cycle(4'b0100, 4'b0100, 1'b1);

        // Reset asserted between clock edges while requester 0 is on beat 2 of 4
        cycle(4'b0001, 4'b0000, 1'b1);
        cycle(4'b0001, 4'b0000, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        valid = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Lock held across a two-cycle bubble; requester 3 follows the last beat
        cycle(4'b1001, 4'b0000, 1'b1);
        cycle(4'b1000, 4'b0000, 1'b1);
        cycle(4'b1000, 4'b0000, 1'b1);
        cycle(4'b1001, 4'b0001, 1'b1);
        cycle(4'b1000, 4'b1000, 1'b1);

        // Backpressure then release
        repeat (5) cycle(4'b0101, 4'b0101, 1'b0);
        cycle(4'b0101, 4'b0101, 1'b1);
        cycle(4'b0101, 4'b0101, 1'b1);

        // Pointer to 2, then a request set that must wrap back to 0
        cycle(4'b0010, 4'b0010, 1'b1);
        cycle(4'b0011, 4'b0011, 1'b1);
        cycle(4'b0010, 4'b0010, 1'b1);

        // Randomized traffic with packets, bubbles and backpressure
        for (int c = 0; c < 600; c++) begin
            logic [3:0] rv, rl;
            rv = 4'($urandom_range(0, 15));
            rl = 4'($urandom & $urandom);
            cycle(rv, rl, ($urandom_range(0, 3) != 0));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("drain n4", 64'(q4.size()), 64'd0);
        chk("drain n3", 64'(q3.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
